note_rom_arbiter: RTL
=====================

Name: note_rom_arbiter

Overview:
- Shares one synchronous song ROM among NUM_CH note-sequencer channels (e.g. pulse1, pulse2, triangle, noise).
- Each channel requests a 5-bit note index.
- The arbiter grants channels round-robin, drives the ROM with {channel, index}, and returns the 16-bit note word to the requester with a one-cycle ack.
- Sits between the per-channel sequencers and the single ROM block RAM.

Parameters:
- NUM_CH, 4, number of requesting channels (power of two, 2..8).
- CH_W, 2, log2(NUM_CH); upper ROM address bits.
- ADDR_W, 5, per-channel note index width.
- DATA_W, 16, ROM word width.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset.
- i_req  input  NUM_CH  per-channel read request, level.
- i_addr  input  NUM_CH*ADDR_W  per-channel note index; channel k occupies bits [k*ADDR_W +: ADDR_W].
- o_ack  output  NUM_CH  one-hot, one-cycle pulse: o_data valid for that channel.
- o_data  output  DATA_W  ROM word for the acked channel; holds until the next ack.
- o_rom_en  output  1  ROM read enable.
- o_rom_addr  output  CH_W+ADDR_W  ROM address = {channel, index}.
- i_rom_data  input  DATA_W  ROM output, valid one cycle after the edge that samples o_rom_en=1.

Behaviour:
- Reset is i_rst, synchronous, active-high; clock is i_clk.
- Reset values: state IDLE, o_ack=0, o_data=0, o_rom_en=0, o_rom_addr=0, RR pointer=0.
- State machine is IDLE -> WAIT -> CAPT -> IDLE. All outputs are registered.
- IDLE:
  - Candidate set = i_req & ~o_ack (the channel acked this cycle is masked, so a requester holding req one cycle late is not re-granted).
  - If the set is non-empty, grant the first set bit searching upward from the RR pointer, wrapping modulo NUM_CH.
  - On grant: register o_rom_addr = {grant, i_addr[grant]}, o_rom_en=1, latch grant id, go WAIT.
  - If the set is empty, stay in IDLE with o_rom_en=0.
- WAIT: o_rom_en<=0 at the exiting edge; the ROM samples the address on that edge; go CAPT.
- CAPT:
  - o_data<=i_rom_data.
  - o_ack<=one-hot(grant).
  - RR pointer<=grant+1 (wraps NUM_CH-1 -> 0).
  - Go IDLE.
- o_ack self-clears the following cycle.
- Latency: req high at edge E0 (IDLE) -> o_rom_en high E0..E1 -> o_ack high in the cycle after E2 (3 cycles).
- Throughput: one grant per 3 cycles, with back-to-back service under continuous requests.
- Requester rules:
  - Hold i_req and i_addr stable until o_ack.
  - Drop i_req in the cycle o_ack is seen, or the next cycle at the latest.
  - i_req still high two cycles after ack is a new request.
- The address is sampled only at grant; changes after grant are ignored for the current transaction.
- Req withdrawn before grant: never granted, no ack.
- Req withdrawn after grant: the transaction completes and the ack still pulses.
- Fairness: with all channels requesting continuously, the grant order is 0,1,2,3,0,...; no channel waits more than NUM_CH-1 other grants.
- Simultaneous requests arriving in the same cycle: resolved purely by RR pointer order.
- Reset mid-transaction (WAIT or CAPT): aborts the transaction, no ack is emitted, all reset values are restored on the next edge.
- Exactly one transaction is in flight at a time. o_ack is never multi-hot, and o_rom_en is high for exactly one cycle per grant.

Test Plan:
- Reset then idle, i_req=0 for 20 cycles -> o_rom_en, o_ack, o_data stay 0.
- Single request, i_req=4'b0100, ch2 index=5'd7, ROM[{2,7}]=16'h0A5C:
  - o_rom_addr=7'b10_00111 with o_rom_en high one cycle.
  - o_ack=4'b0100 three cycles after req with o_data=16'h0A5C.
  - No re-grant when req is dropped the cycle after ack.
- All four channels requesting continuously, each with a distinct index:
  - Acks in order ch0,ch1,ch2,ch3,ch0, spaced 3 cycles apart.
  - Each o_data matches ROM[{ch,idx}].
- Pointer at 2 after a ch1 service, then ch0 and ch3 request together -> ch3 acked first, then ch0.
- Requester holds req one cycle into the ack (i_req=0001 during the ack cycle, then 0) -> exactly one ack, no second ROM read.
- i_rst asserted during WAIT with ch1 granted -> no o_ack ever for that grant, o_rom_en=0, pointer=0. A later ch1+ch3 request is served ch1 first.

Source files
------------

// File: rtl/note_rom_arbiter.sv
// Round-robin arbiter that shares one synchronous song ROM among NUM_CH note channels.
// Each grant reads ROM[{channel, index}] and returns the word with a one-cycle one-hot ack.
module note_rom_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_CH-1:0]        i_req,
  input  logic [NUM_CH*ADDR_W-1:0] i_addr,
  output logic [NUM_CH-1:0]        o_ack,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_rom_en,
  output logic [CH_W+ADDR_W-1:0]   o_rom_addr,
  input  logic [DATA_W-1:0]        i_rom_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CAPT = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [CH_W-1:0]          ptr;
  logic [CH_W-1:0]          ptr_nxt;
  logic [CH_W-1:0]          grant;
  logic [CH_W-1:0]          grant_nxt;
  logic [NUM_CH-1:0]        ack_nxt;
  logic [DATA_W-1:0]        data_nxt;
  logic                     rom_en_nxt;
  logic [CH_W+ADDR_W-1:0]   rom_addr_nxt;

  logic [NUM_CH-1:0]        cand;
  logic [CH_W-1:0]          probe;
  logic [CH_W-1:0]          pick;
  logic                     found;
  logic [ADDR_W-1:0]        pick_idx;

  // Round-robin search upward from ptr; the channel being acked right now is masked out.
  always_comb begin
    cand  = i_req & ~o_ack;
    found = 1'b0;
    pick  = '0;
    probe = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      probe = ptr + CH_W'(i);
      if (!found && cand[probe]) begin
        found = 1'b1;
        pick  = probe;
      end
    end
    pick_idx = i_addr[pick*ADDR_W +: ADDR_W];
  end

  // Register block: state, pointer, grant id and all outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      ptr        <= '0;
      grant      <= '0;
      o_ack      <= '0;
      o_data     <= '0;
      o_rom_en   <= 1'b0;
      o_rom_addr <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      grant      <= grant_nxt;
      o_ack      <= ack_nxt;
      o_data     <= data_nxt;
      o_rom_en   <= rom_en_nxt;
      o_rom_addr <= rom_addr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (found) state_nxt = WAIT;
      WAIT:    state_nxt = CAPT;
      CAPT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs; ROM data is captured one cycle after the read edge.
  always_comb begin
    ack_nxt      = '0;
    data_nxt     = o_data;
    rom_en_nxt   = 1'b0;
    rom_addr_nxt = o_rom_addr;
    grant_nxt    = grant;
    ptr_nxt      = ptr;
    unique case (state)
      IDLE: begin
        if (found) begin
          rom_en_nxt   = 1'b1;
          rom_addr_nxt = {pick, pick_idx};
          grant_nxt    = pick;
        end
      end
      CAPT: begin
        data_nxt = i_rom_data;
        ack_nxt  = NUM_CH'(1) << grant;
        ptr_nxt  = grant + CH_W'(1);
      end
      default: ;
    endcase
  end

endmodule
